// File: rtl/rle_row_decoder.sv
// Expands packed {run, value} RLE symbols back into 64-coefficient blocks,
// emitted as eight 64-bit rows of eight 8-bit coefficients.
//
// state  | meaning
// S_IDLE | waiting for a packed word
// S_DEC  | decoding symbol sym_idx of the captured word
// S_RUN  | writing the zeros owed by a run, then the symbol value
// S_EOB  | zero-filling and emitting the remaining rows of the block
module rle_row_decoder #(
    parameter logic [5:0] EOB_RUN  = 6'd63,
    parameter logic [7:0] EOB_VAL  = 8'h7F,
    parameter int         BLK_COEF = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [111:0] in_data_i,
    input  logic [3:0]   in_count_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [63:0]  out_data_o,
    output logic         out_last_o,
    output logic         err_o
);

    localparam logic [6:0] POS_END  = 7'(BLK_COEF);
    localparam logic [7:0] LAST_POS = 8'(BLK_COEF - 1);

    typedef enum logic [1:0] {S_IDLE, S_DEC, S_RUN, S_EOB} state_t;

    state_t         state_q;
    logic [111:0]   word_q;
    logic [3:0]     cnt_q;
    logic [2:0]     sym_idx_q;
    logic [6:0]     pos_q;
    logic [5:0]     run_left_q;
    logic [63:0]    row_buf_q;
    logic [63:0]    out_data_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           err_q;

    logic           stall;
    logic [13:0]    sym;
    logic [5:0]     sym_run;
    logic [7:0]     sym_val;
    logic           is_eob;
    logic           overflow;
    logic           last_sym;
    logic [3:0]     cnt_in;
    logic           wr_en;
    logic [7:0]     wr_val;
    logic [63:0]    row_d;

    assign stall       = out_valid_q && !out_ready_i;
    assign in_ready_o  = (state_q == S_IDLE) && !stall;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign err_o       = err_q;

    assign cnt_in   = (in_count_i == 4'd0 || in_count_i > 4'd8) ? 4'd8 : in_count_i;
    assign sym_run  = sym[13:8];
    assign sym_val  = sym[7:0];
    assign is_eob   = (sym_run == EOB_RUN) && (sym_val == EOB_VAL);
    assign overflow = ({1'b0, pos_q} + {2'b00, sym_run}) > LAST_POS;
    assign last_sym = ({1'b0, sym_idx_q} == (cnt_q - 4'd1));

    always_comb begin
        sym = word_q[111 -: 14];
        for (int k = 1; k < 8; k++) begin
            if (sym_idx_q == 3'(k)) sym = word_q[111 - 14*k -: 14];
        end
    end

    // Coefficient written this cycle, and the row buffer with it merged in
    always_comb begin
        wr_en  = 1'b0;
        wr_val = 8'h00;
        case (state_q)
            S_DEC: begin
                if (!is_eob && !overflow) begin
                    wr_en  = 1'b1;
                    wr_val = (sym_run == 6'd0) ? sym_val : 8'h00;
                end
            end
            S_RUN: begin
                wr_en  = 1'b1;
                wr_val = (run_left_q == 6'd0) ? sym_val : 8'h00;
            end
            default: ;
        endcase
        row_d = row_buf_q;
        for (int s = 0; s < 8; s++) begin
            if (pos_q[2:0] == 3'(s)) row_d[63 - 8*s -: 8] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            cnt_q       <= 4'd0;
            sym_idx_q   <= 3'd0;
            pos_q       <= 7'd0;
            run_left_q  <= 6'd0;
            row_buf_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
            if (!stall) begin
                if (wr_en) begin
                    pos_q <= pos_q + 7'd1;
                    if (pos_q[2:0] == 3'd7) begin
                        out_data_q  <= row_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (pos_q[5:3] == 3'd7);
                        row_buf_q   <= '0;
                    end else begin
                        row_buf_q <= row_d;
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        if (in_valid_i) begin
                            word_q    <= in_data_i;
                            cnt_q     <= cnt_in;
                            sym_idx_q <= 3'd0;
                            state_q   <= S_DEC;
                        end
                    end
                    S_DEC: begin
                        if (is_eob) begin
                            state_q <= S_EOB;
                        end else if (overflow || sym_run == 6'd0) begin
                            err_q     <= overflow;
                            sym_idx_q <= sym_idx_q + 3'd1;
                            state_q   <= last_sym ? S_IDLE : S_DEC;
                        end else begin
                            run_left_q <= sym_run - 6'd1;
                            state_q    <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (run_left_q != 6'd0) begin
                            run_left_q <= run_left_q - 6'd1;
                        end else begin
                            sym_idx_q <= sym_idx_q + 3'd1;
                            state_q   <= last_sym ? S_IDLE : S_DEC;
                        end
                    end
                    S_EOB: begin
                        if (pos_q == POS_END) begin
                            pos_q     <= 7'd0;
                            sym_idx_q <= sym_idx_q + 3'd1;
                            state_q   <= last_sym ? S_IDLE : S_DEC;
                        end else begin
                            // Unwritten slots of row_buf are already zero
                            out_data_q  <= row_buf_q;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (pos_q[5:3] == 3'd7);
                            row_buf_q   <= '0;
                            if (pos_q[5:3] == 3'd7) begin
                                pos_q     <= 7'd0;
                                sym_idx_q <= sym_idx_q + 3'd1;
                                state_q   <= last_sym ? S_IDLE : S_DEC;
                            end else begin
                                pos_q <= {pos_q[6:3] + 4'd1, 3'b000};
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rle_row_decoder.sv
// Directed bench for rle_row_decoder: expected rows are queued as each block
// is sent and checked against every accepted output row.
module tb_rle_row_decoder;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [111:0] in_data;
    logic [3:0]   in_count;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_last;
    logic         err;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } row_t;

    row_t exp_q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   err_cnt = 0;
    int   err_base;
    bit   seen;

    localparam logic [13:0] EOB = {6'd63, 8'h7F};

    always #5 clk = ~clk;

    rle_row_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_count_i (in_count),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .err_o      (err)
    );

    // Output monitor: pops the scoreboard on every accepted row
    always @(negedge clk) begin
        row_t e;
        if (reset && err) err_cnt++;
        if (reset && out_valid && out_ready) begin
            tests++;
            assert (exp_q.size() != 0)
            else begin
                fails++;
                $error("FAIL unexpected_row got %h exp none", out_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                assert (out_data === e.d)
                else begin
                    fails++;
                    $error("FAIL row_data got %h exp %h", out_data, e.d);
                end
                tests++;
                assert (out_last === e.l)
                else begin
                    fails++;
                    $error("FAIL row_last got %b exp %b (data %h)", out_last, e.l, e.d);
                end
            end
        end
    end

    function automatic logic [13:0] sym(input logic [5:0] r, input logic [7:0] v);
        return {r, v};
    endfunction

    function automatic logic [111:0] dense_word(input int w);
        logic [111:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[111 - 14*k -: 14] = {6'd0, 8'(8*w + k + 1)};
        return d;
    endfunction

    function automatic logic [63:0] dense_row(input int r);
        logic [63:0] d;
        for (int s = 0; s < 8; s++) d[63 - 8*s -: 8] = 8'(8*r + s + 1);
        return d;
    endfunction

    task automatic push_row(input logic [63:0] d, input logic l);
        row_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic push_dc_block();
        push_row(64'h0500000000000000, 1'b0);
        for (int r = 1; r < 8; r++) push_row(64'h0, r == 7);
    endtask

    task automatic push_runs_block();
        push_row(64'h1100002200000000, 1'b0);
        push_row(64'h0033000000000000, 1'b0);
        for (int r = 2; r < 8; r++) push_row(64'h0, r == 7);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        assert (got === expv)
        else begin
            fails++;
            $error("FAIL %s got %h exp %h", tag, got, expv);
        end
    endtask

    // Called just after a rising edge; returns just after the capturing edge
    task automatic send_word(input logic [3:0] cnt, input logic [111:0] data);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        in_count = cnt;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tests++;
        assert (ok)
        else begin
            fails++;
            $error("FAIL send_timeout got in_ready=0 exp in_ready=1 within 300 cycles");
        end
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && in_ready && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        assert (ok)
        else begin
            fails++;
            $error("FAIL drain_timeout got %0d rows pending exp 0", exp_q.size());
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_count  = 4'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // DC-only block
        push_dc_block();
        send_word(4'd2, {sym(6'd0, 8'h05), EOB, 84'b0});
        drain(200);
        chk("dc_err_count", 64'(err_cnt), 64'd0);

        // Runs of zeros
        err_base = err_cnt;
        push_runs_block();
        send_word(4'd4, {sym(6'd0, 8'h11), sym(6'd2, 8'h22), sym(6'd5, 8'h33), EOB, 56'b0});
        drain(200);
        chk("runs_err_count", 64'(err_cnt - err_base), 64'd0);

        // Dense block; word counts 0 and 12 must both behave as 8
        for (int r = 0; r < 8; r++) push_row(dense_row(r), r == 7);
        for (int w = 0; w < 8; w++) begin
            send_word((w == 2) ? 4'd0 : (w == 5) ? 4'd12 : 4'd8, dense_word(w));
        end
        send_word(4'd1, {EOB, 98'b0});
        drain(200);

        // Backpressure on the first row of the runs block
        push_runs_block();
        out_ready = 1'b0;
        send_word(4'd4, {sym(6'd0, 8'h11), sym(6'd2, 8'h22), sym(6'd5, 8'h33), EOB, 56'b0});
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        assert (seen)
        else begin
            fails++;
            $error("FAIL bp_row_timeout got out_valid=0 exp out_valid=1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_data", out_data, exp_q[0].d);
            chk("bp_out_last", 64'(out_last), 64'(exp_q[0].l));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(200);

        // Overflow at pos 60: dropped symbol, next value lands in slot 4
        err_base = err_cnt;
        for (int r = 0; r < 7; r++) push_row(64'h0, 1'b0);
        push_row(64'h0000000155000000, 1'b1);
        send_word(4'd4, {sym(6'd59, 8'h01), sym(6'd10, 8'h44), sym(6'd0, 8'h55), EOB, 56'b0});
        drain(300);
        chk("ovf_err_cycles", 64'(err_cnt - err_base), 64'd1);

        // Reset after four rows of a block, then a clean DC block
        for (int r = 0; r < 4; r++) push_row(dense_row(r), 1'b0);
        for (int w = 0; w < 4; w++) send_word(4'd8, dense_word(w));
        drain(200);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        err_base = err_cnt;
        push_dc_block();
        send_word(4'd2, {sym(6'd0, 8'h05), EOB, 84'b0});
        drain(200);
        chk("post_rst_err_count", 64'(err_cnt - err_base), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rle_row_decoder.md
Name: rle_row_decoder

Overview:
- Inverse of the JPEG run-length packer.
- Accepts 112-bit words, each holding up to eight 14-bit {run[5:0], value[7:0]} symbols.
- Expands them back into 64-coefficient blocks, emitted as eight 64-bit rows of eight 8-bit coefficients.
- Sits between the RLE memory read port and the inverse zigzag/IDCT path, with valid/ready handshakes on both sides.

Parameters:
- EOB_RUN, 6'd63, run field of the end-of-block marker.
- EOB_VAL, 8'h7F, value field of the end-of-block marker.
- BLK_COEF, 64, coefficients per block; must be 64.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data/in_count hold a word.
- in_ready  output  1  decoder will accept a word this cycle.
- in_data  input  112  packed symbols; symbol k at [111-14k -: 14], k=0 first; run in the upper 6 bits.
- in_count  input  4  number of valid symbols in the word, 1..8; 0 or >8 is treated as 8.
- out_valid  output  1  out_data holds a completed row.
- out_ready  input  1  consumer takes the row this cycle.
- out_data  output  64  row; coefficient at block position p sits at [63-8*(p%8) -: 8].
- out_last  output  1  qualifies out_data as row 7 (final row) of the block.
- err  output  1  one-cycle pulse: a symbol was dropped.

Behaviour:
- Reset is synchronous on the clk edge while reset==0:
  - out_valid=0, out_data=0, out_last=0, err=0.
  - state=S_IDLE, pos=0, sym_idx=0, run_left=0, row buffer cleared.
  - in_ready reads 1 in the first cycle after reset is released.
  - Reset mid-block discards all partial data; no row is emitted.
- in_ready = (state==S_IDLE) && !stall. A word is captured on in_valid&&in_ready, along with cnt=in_count (clamped to 1..8) and sym_idx=0.
- stall = out_valid && !out_ready. While stalled:
  - no state, counter or buffer changes;
  - out_data and out_last are held stable.
- Counters:
  - pos[6:0]: next block position, 0..64.
  - run_left[5:0]: zeros still owed for the current symbol.
  - row_buf[63:0]: the row being assembled.
- Writing a coefficient puts it at row_buf slot pos%8, then increments pos.
  - If the slot written is 7, on the same edge: out_data <= completed row, out_valid <= 1, out_last <= (pos[5:3]==7), and row_buf is cleared.
  - out_valid clears on out_valid&&out_ready unless a new row loads on the same edge.
- S_IDLE: wait for a word. On capture go to S_DEC.
- S_DEC decodes symbol sym_idx, one cycle per decision:
  - If the symbol is EOB ({EOB_RUN, EOB_VAL}): go to S_EOB.
  - Else if pos + run > 63: pulse err, drop the symbol, advance.
  - Else if run==0: write value, advance.
  - Else: write 0, set run_left = run-1, go to S_RUN.
- S_RUN: write 0 per cycle while run_left > 0, decrementing run_left. When run_left==0, write the value and advance.
- Advance: if sym_idx==cnt-1 go to S_IDLE, else sym_idx+1 and return to S_DEC.
- S_EOB:
  - If pos==64: pos=0, advance; consumes 1 cycle, emits nothing.
  - Else: each cycle, zero-fill slots pos%8..7 and emit the row; pos rounds up to the next multiple of 8. After the row with out_last=1 is emitted, pos=0 and advance.
- pos==64 with a non-EOB symbol: err pulse, symbol dropped, pos is unchanged.
- Latency and throughput:
  - first symbol is decoded the cycle after word capture;
  - a symbol costs run+1 cycles; EOB costs the number of rows remaining (minimum 1);
  - one idle bubble per word.
- A value of 0 with any run is legal and is written as a literal zero.

Test Plan:
1. DC only: word cnt=2 {0,0x05},{63,0x7F}, out_ready=1 -> 8 rows. Row0=0x0500000000000000, rows1-7=0, out_last only on the 8th row, pos back to 0.
2. Runs: cnt=4 {0,0x11},{2,0x22},{5,0x33},EOB -> row0=0x1100002200000000, row1=0x0033000000000000, rows2-7=0, err never set.
3. Dense block: 8 words of run-0 values 0x01..0x40, then a word cnt=1 EOB -> exactly 8 rows. Row0=0x0102030405060708, row7=0x393A3B3C3D3E3F40 with out_last; EOB emits no extra row.
4. Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> out_data/out_last stable, in_ready=0, pos/sym_idx frozen. Decode resumes the cycle after out_ready=1.
5. Overflow: pos=60, symbol {10,0x44} -> err=1 for one cycle, pos stays 60. Next symbol {0,0x55} lands in slot 4.
6. Reset mid-block: reset low for one edge after row 3 -> out_valid=0 and in_ready=1 next cycle. A new DC-only block then decodes exactly as in scenario 1.
